instr_fetch_unit: RTL and testbench

//  Supplier side of the core's instruction input: generates the PC stream, fetches words from

---
 rtl/instr_fetch_unit.sv | 184 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Supplies the core's instruction input. It generates the PC stream, fetches
// words from instruction memory over a req/ack bus (one request outstanding at
// most), and hands {instr, pc} pairs to the core through a small prefetch FIFO
// with a valid/ready handshake. A redirect pulse flushes everything queued and
// restarts fetching at the new PC. A request already on the bus when the
// redirect arrives is allowed to finish, and its data is thrown away.
//
// Parameters
//   RESET_PC    PC of the first fetch after reset (word aligned)
//   FIFO_DEPTH  prefetch entries (power of 2, >= 2)
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high
//   imem_req     out  1   fetch request, held until imem_ack
//   imem_addr    out  32  word-aligned fetch address, stable while waiting
//   imem_ack     in   1   request accepted, imem_rdata valid this cycle
//   imem_rdata   in   32  instruction word at imem_addr
//   instr        out  32  head-of-FIFO instruction (0 when empty)
//   instr_pc     out  32  PC of instr (0 when empty)
//   instr_valid  out  1   FIFO non-empty
//   instr_ready  in   1   core takes the head when instr_valid & instr_ready
//   redirect     in   1   one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc  in   32  new PC, bits [1:0] ignored
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    logic          space;
    logic          load_addr;

    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   fifo_pc    [FIFO_DEPTH];

    // Word-align a PC; low bits of a redirect target are simply cleared.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

    // ------------------------------------------------------------------
    // State / control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            count    <= count_next;
            if (load_addr) begin
                imem_addr <= fetch_pc_next;
            end
            // A flush realigns both pointers; the stored data is left as is
            // since nothing reads it until it is overwritten.
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    // FIFO storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= imem_addr;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Redirect empties the FIFO outright; a pop in the same cycle is not
        // counted, so the occupancy simply becomes zero.
        if (redirect) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end

        if (redirect) begin
            fetch_pc_next = align_pc(redirect_pc);
        end else if (push) begin
            fetch_pc_next = fetch_pc + 32'd4;   // wraps past 32'hFFFF_FFFC
        end else begin
            fetch_pc_next = fetch_pc;
        end

        // A new request is only issued when its word is guaranteed a slot,
        // counting this edge's push and pop.
        space = (count_next < DEPTH_C);

        state_next = state;
        case (state)
            IDLE: begin
                if (!redirect && space) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    state_next = (!redirect && space) ? FETCH : IDLE;
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // The address only moves when a fresh request begins, never while one
        // is waiting for its ack.
        load_addr = (state_next == FETCH) && ((state == IDLE) || imem_ack);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem_req    = (state != IDLE);
        instr_valid = (count != '0);
        push        = (state == FETCH) && imem_ack && !redirect;
        pop         = instr_valid && instr_ready && !redirect;
        instr       = instr_valid ? fifo_instr[rd_ptr] : 32'h0;
        instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : 32'h0;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    // Second instance: wrap-around start PC, zero-wait memory, always ready.
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ack2;
    logic [31:0] imem_rdata2;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;
    logic        instr_valid2;
    logic        instr_ready2;
    logic        redirect2;
    logic [31:0] redirect_pc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
        .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
        .instr_ready(instr_ready2), .redirect(redirect2), .redirect_pc(redirect_pc2)
    );

    // Memory contents: a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model for the main instance: ack after cur_lat waiting cycles.
    int fixed_lat = 0;
    bit rand_lat  = 1'b0;
    int cur_lat   = 0;
    int wait_cnt  = 0;

    assign imem_ack   = imem_req && (wait_cnt >= cur_lat);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk) begin
        if (!imem_req || imem_ack) begin
            wait_cnt <= 0;
            cur_lat  <= rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    assign imem_ack2    = imem_req2;
    assign imem_rdata2  = mem_word(imem_addr2);
    assign instr_ready2 = 1'b1;
    assign redirect2    = 1'b0;
    assign redirect_pc2 = 32'h0;

    // Bus rule monitor: address must not move while a request waits.
    logic [31:0] prev_addr = 32'h0;
    bit          prev_wait = 1'b0;
    int          addr_viol = 0;
    always @(negedge clk) begin
        if (prev_wait && imem_req && (imem_addr !== prev_addr)) begin
            addr_viol <= addr_viol + 1;
        end
        prev_wait <= imem_req && !imem_ack;
        prev_addr <= imem_addr;
    end

    // Reference model: the core must see a contiguous PC sequence starting
    // at the reset PC or the latest redirect target, each with mem_word(pc).
    logic [31:0] exp_pc   = 32'h0;
    int          consumed = 0;
    bit          last_pop = 1'b0;

    // Called at a negedge: drive one cycle of inputs, score any pop, and
    // return at the following negedge.
    task automatic drive_cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        last_pop    = instr_valid && rdy && !redir;
        if (redir) begin
            exp_pc = rpc & 32'hFFFF_FFFC;
        end else if (last_pop) begin
            checks++;
            if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                errors++;
                $display("FAIL stream got pc=%h instr=%h need pc=%h instr=%h",
                         instr_pc, instr, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b need 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h need 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b need 0", instr_valid); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr got %h/%h need 0/0", instr, instr_pc); end
        checks++; if (imem_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_addr2 got %h need fffffff8", imem_addr2); end
        reset  = 1'b0;
        exp_pc = 32'h0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL first_valid_early got %b need 0", instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got %b/%h need 1/0", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL first_valid got %b/%h need 1/0", instr_valid, instr_pc); end
    endtask

    task automatic test_stream;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, 1'b0, 32'h0);
            checks++;
            if (!last_pop) begin errors++; $display("FAIL throughput cycle %0d got no instr need one", i); end
        end
    endtask

    task automatic test_fill;
        int  run;
        bit  stop;
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fill_req_drop got %b need 0", imem_req); end
        fixed_lat = 8;
        run  = 0;
        stop = 1'b0;
        for (int i = 0; i < 10 && !stop; i++) begin
            drive_cycle(1'b1, 1'b0, 32'h0);
            if (last_pop) run++;
            else stop = 1'b1;
        end
        checks++; if (run != 4) begin errors++; $display("FAIL fill_entries got %0d need 4", run); end
        fixed_lat = 0;
    endtask

    task automatic test_redirect_wait;
        logic [31:0] held;
        bit          seen;
        int          n;
        fixed_lat = 3;
        n = 0;
        while (!(imem_req && !imem_ack) && n < 30) begin drive_cycle(1'b1, 1'b0, 32'h0); n++; end
        checks++; if (!(imem_req && !imem_ack)) begin errors++; $display("FAIL t3_wait got req=%b ack=%b need 1/0", imem_req, imem_ack); end
        held = imem_addr;
        drive_cycle(1'b1, 1'b1, 32'h0000_0100);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL t3_flush got valid %b need 0", instr_valid); end
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== held) begin
                errors++; $display("FAIL t3_hold got %b/%h need 1/%h", imem_req, imem_addr, held);
            end
            if (imem_ack) seen = 1'b1;
            drive_cycle(1'b1, 1'b0, 32'h0);
        end
        checks++; if (!seen) begin errors++; $display("FAIL t3_ack_timeout got none need ack"); end
        n = 0;
        while (!imem_req && n < 5) begin drive_cycle(1'b1, 1'b0, 32'h0); n++; end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL t3_new_addr got %b/%h need 1/00000100", imem_req, imem_addr); end
        for (int i = 0; i < 16; i++) drive_cycle(1'b1, 1'b0, 32'h0);
        checks++; if (exp_pc == 32'h0000_0100) begin errors++; $display("FAIL t3_delivery got none need pc 00000100"); end
    endtask

    task automatic test_redirect_ack_pop;
        logic [31:0] rpc;
        logic [31:0] ra;
        int          n;
        fixed_lat = 0;
        n = 0;
        while (!(imem_req && imem_ack && instr_valid) && n < 30) begin drive_cycle(1'b1, 1'b0, 32'h0); n++; end
        checks++; if (!(imem_req && imem_ack && instr_valid)) begin errors++; $display("FAIL t4_setup got req=%b ack=%b valid=%b need 1/1/1", imem_req, imem_ack, instr_valid); end
        rpc = $urandom;
        ra  = rpc & 32'hFFFF_FFFC;
        drive_cycle(1'b1, 1'b1, rpc);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL t4_flush got valid %b need 0", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t4_idle got req %b need 0", imem_req); end
        drive_cycle(1'b1, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== ra) begin errors++; $display("FAIL t4_new_addr got %b/%h need 1/%h", imem_req, imem_addr, ra); end
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, 32'h0);
        checks++; if (exp_pc == ra) begin errors++; $display("FAIL t4_delivery got none need pc %h", ra); end
    endtask

    task automatic test_random;
        int c0;
        c0 = consumed;
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4, $urandom);
        end
        rand_lat = 1'b0;
        checks++; if (addr_viol != 0) begin errors++; $display("FAIL addr_stable got %0d changes need 0", addr_viol); end
        checks++; if (consumed - c0 < 40) begin errors++; $display("FAIL random_progress got %0d instrs need >=40", consumed - c0); end
    endtask

    task automatic test_reset_mid;
        int n;
        int c0;
        fixed_lat = 5;
        n = 0;
        while (!(imem_req && !imem_ack) && n < 20) begin drive_cycle(1'b1, 1'b0, 32'h0); n++; end
        checks++; if (!(imem_req && !imem_ack)) begin errors++; $display("FAIL t6_setup got req=%b ack=%b need 1/0", imem_req, imem_ack); end
        #2 reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t6_async_req got %b need 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL t6_async_valid got %b need 0", instr_valid); end
        @(negedge clk);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL t6_addr got %h need 0", imem_addr); end
        fixed_lat = 0;
        reset  = 1'b0;
        exp_pc = 32'h0;
        c0 = consumed;
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, 32'h0);
        checks++; if (consumed - c0 < 6) begin errors++; $display("FAIL t6_restart got %0d instrs need >=6", consumed - c0); end
    endtask

    task automatic test_wrap;
        logic [31:0] q_pc[$];
        logic [31:0] q_in[$];
        logic [31:0] want;
        instr_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (instr_valid2 !== 1'b0 || imem_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_reset got %b/%h need 0/fffffff8", instr_valid2, imem_addr2); end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (instr_valid2) begin q_pc.push_back(instr_pc2); q_in.push_back(instr2); end
        end
        checks++;
        if (q_pc.size() < 3) begin
            errors++; $display("FAIL wrap_count got %0d need >=3", q_pc.size());
        end else begin
            want = 32'hFFFF_FFF8;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_pc[i] !== want || q_in[i] !== mem_word(want)) begin
                    errors++; $display("FAIL wrap_pc%0d got %h/%h need %h/%h", i, q_pc[i], q_in[i], want, mem_word(want));
                end
                want = want + 32'd4;
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_fill();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
